uart_tx_drain: RTL
==================

# uart_tx_drain

Serial UART transmitter that drains the byte FIFO directly downstream of it. The block pops one word at a time through the FIFO's read port (rd / o_data / o_valid / empty) and shifts it out as an asynchronous serial frame: start bit, LSB-first data, optional even parity, and 1 or 2 stop bits. It sits between the TX FIFO and the device pin and is the only consumer of that FIFO.

## Interface
- DATA_WIDTH, 8: data bits per frame; must match the FIFO width.
- CLKS_PER_BIT, 16: clock cycles per serial bit; must be ≥ 2.
- PARITY_EN, 0: 1 inserts an even-parity bit after the data bits.
- STOP_BITS, 1: number of stop bits, 1 or 2.

- clk  input  1  system clock; all logic is on the rising edge
- rst  input  1  synchronous, active-high reset
- enable  input  1  permits new FIFO fetches; has no effect on a frame already in progress
- fifo_empty  input  1  FIFO empty flag
- fifo_rd  output  1  FIFO read strobe
- fifo_data  input  DATA_WIDTH  FIFO read data
- fifo_valid  input  1  FIFO read-data valid; arrives one cycle after an accepted rd
- tx  output  1  serial line; idles high
- busy  output  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, FETCH, START, DATA, PARITY, STOP.
- IDLE:
  - fifo_rd = enable && !fifo_empty (combinational).
  - If fifo_rd is high, go to FETCH.
- FETCH:
  - If fifo_valid, latch fifo_data into the shift register, compute parity = XOR of all data bits, and go to START.
  - If !fifo_valid (protocol violation), go to IDLE with nothing transmitted.
- START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - Send bit 0 first.
  - Each bit is held CLKS_PER_BIT cycles.
  - bit_cnt runs 0..DATA_WIDTH-1.
  - After the last bit, go to PARITY if PARITY_EN, otherwise go to STOP.
- PARITY: tx = parity for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - tx = 1 for STOP_BITS × CLKS_PER_BIT cycles, then go to IDLE.
  - No prefetch is done during STOP.
- Counter widths:
  - baud_cnt is $clog2(CLKS_PER_BIT) bits; it counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - bit_cnt is $clog2(DATA_WIDTH)+1 bits.
- enable falling mid-frame: the current frame completes, and no further fifo_rd is issued.
- fifo_rd is issued only in IDLE, so at most one read is ever outstanding.
- Reset:
  - Values: state = IDLE, tx = 1, busy = 0, fifo_rd = 0, counters = 0.
  - Reset during a frame aborts it. tx is high on the cycle after rst is sampled, and the popped byte is discarded.

## Timing
- tx is a registered output, so there are no glitches on the pin.
- Cycle T: fifo_rd high in IDLE.
- T+1: state is FETCH and fifo_valid is high.
- T+2: first cycle of START, tx = 0, so the start bit follows fifo_rd by 2 cycles.
- Frame length: (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles, measured from the first START cycle to the last STOP cycle inclusive.
- Back-to-back frames with the FIFO non-empty and enable high: the gap is exactly 2 extra tx-high cycles (IDLE + FETCH) between the end of STOP and the next START.
- busy rises in the cycle after fifo_rd and falls in the first IDLE cycle.

## Structure
- Package uart_pkg holds the following, for reuse by the future uart_rx:
  - typedef enum logic [2:0] uart_tx_state_t (IDLE, FETCH, START, DATA, PARITY, STOP);
  - constants UART_IDLE_LEVEL = 1'b1 and UART_START_LEVEL = 1'b0.
- One natural sub-module, baud_counter:
  - parameter CLKS_PER_BIT; inputs clk, rst, clear;
  - outputs tick (high in the last cycle of each bit period) and the count.
- The FSM, shift register and parity logic live in uart_tx_drain itself.

## Test plan
Defaults for all cases: CLKS_PER_BIT=4, DATA_WIDTH=8, and the real fifo instance upstream.
- Reset, then idle with the FIFO empty → tx=1, busy=0 and fifo_rd=0 for 100 cycles.
- Push 0xA5 (PARITY_EN=0, STOP_BITS=1) →
  - exactly one fifo_rd pulse;
  - tx falls 2 cycles after fifo_rd;
  - tx = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, 40 cycles total;
  - busy is low afterwards.
- Push 0x00 then 0xFF back-to-back →
  - two fifo_rd pulses;
  - tx high for exactly 2 cycles between the first frame's stop bit and the second start bit;
  - FIFO empty at the end.
- PARITY_EN=1, STOP_BITS=2, push 0x07 → parity bit = 1, 2 stop bits (8 cycles high), frame length 48 cycles.
- enable=0 with 3 bytes queued → no fifo_rd.
- Raise enable, then drop it in the middle of the first frame → that frame completes, no second fifo_rd, 2 bytes remain in the FIFO.
- Assert rst during data bit 3 of 0x5A → tx=1 and busy=0 on the next cycle. After release, the next queued byte transmits normally and 0x5A is not resent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and line levels,
// kept here so the receiver can reuse them.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_t;

   localparam logic UART_IDLE_LEVEL  = 1'b1;
   localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_drain_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick in the
// last cycle of each period.
module baud_counter #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            clear,
   output logic                            tick,
   output logic [$clog2(CLKS_PER_BIT)-1:0] count
);

   localparam int W = $clog2(CLKS_PER_BIT);
   localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

   assign tick = (count == LAST);

   always_ff @(posedge clk) begin
      if (rst || clear || tick) begin
         count <= '0;
      end else begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that pops bytes from the upstream TX FIFO and
// shifts them onto the pin as start/data/parity/stop frames.
module uart_tx_drain
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   output logic                  fifo_rd,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  fifo_valid,
   output logic                  tx,
   output logic                  busy
);

   localparam int BW = $clog2(DATA_WIDTH) + 1;
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   uart_tx_state_t state, state_n;
   logic [DATA_WIDTH-1:0] shreg, shreg_n;
   logic [BW-1:0] bit_cnt, bit_cnt_n;
   logic parity, parity_n;
   logic tx_n;
   logic tick;
   logic clear;
   logic [$clog2(CLKS_PER_BIT)-1:0] unused_baud_cnt;

   // Hold the baud counter at zero until the start bit begins.
   assign clear   = (state == IDLE) || (state == FETCH);
   assign busy    = (state != IDLE);
   assign fifo_rd = (state == IDLE) && enable && !fifo_empty && !rst;

   baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clear(clear),
      .tick (tick),
      .count(unused_baud_cnt)
   );

   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      bit_cnt_n = bit_cnt;
      parity_n  = parity;
      tx_n      = tx;
      unique case (state)
         IDLE: begin
            tx_n = UART_IDLE_LEVEL;
            if (fifo_rd) state_n = FETCH;
         end
         FETCH: begin
            if (fifo_valid) begin
               shreg_n   = fifo_data;
               parity_n  = ^fifo_data;
               bit_cnt_n = '0;
               tx_n      = UART_START_LEVEL;
               state_n   = START;
            end else begin
               state_n = IDLE;
            end
         end
         START: begin
            if (tick) begin
               tx_n    = shreg[0];
               state_n = DATA;
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_cnt == LAST_BIT) begin
                  bit_cnt_n = '0;
                  if (PARITY_EN != 0) begin
                     tx_n    = parity;
                     state_n = PARITY;
                  end else begin
                     tx_n    = UART_IDLE_LEVEL;
                     state_n = STOP;
                  end
               end else begin
                  bit_cnt_n = bit_cnt + BW'(1);
                  shreg_n   = shreg >> 1;
                  tx_n      = shreg_n[0];
               end
            end
         end
         PARITY: begin
            if (tick) begin
               tx_n    = UART_IDLE_LEVEL;
               state_n = STOP;
            end
         end
         STOP: begin
            // bit_cnt is reused to count stop bits.
            if (tick) begin
               if (bit_cnt == LAST_STOP) begin
                  bit_cnt_n = '0;
                  state_n   = IDLE;
               end else begin
                  bit_cnt_n = bit_cnt + BW'(1);
               end
            end
         end
         default: begin
            tx_n    = UART_IDLE_LEVEL;
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         tx      <= UART_IDLE_LEVEL;
         shreg   <= '0;
         bit_cnt <= '0;
         parity  <= 1'b0;
      end else begin
         state   <= state_n;
         tx      <= tx_n;
         shreg   <= shreg_n;
         bit_cnt <= bit_cnt_n;
         parity  <= parity_n;
      end
   end

endmodule
